// File: rtl/context_swap_unit_pkg.sv
// Shared definitions for the context swap unit: FSM encoding and frame layout.
package context_swap_unit_pkg;

  localparam int FRAME_WORDS = 33;
  localparam int PC_SLOT     = 32;
  localparam int CNT_WIDTH   = 6;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    SAVE          = 3'd1,
    SAVE_PC       = 3'd2,
    RESTORE       = 3'd3,
    RESTORE_DRAIN = 3'd4,
    DONE          = 3'd5
  } state_e;

endpackage

// File: rtl/context_swap_unit_frame_counter.sv
// Frame word counter with terminal flags and the wrapping base + i address adder.
module context_frame_counter
  import context_swap_unit_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      inc,
  input  logic [MEM_ADDR_WIDTH-1:0] base,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      last_reg,
  output logic                      pc_slot,
  output logic [MEM_ADDR_WIDTH-1:0] frame_address
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign last_reg = (count_q == CNT_WIDTH'(PC_SLOT - 1));
  assign pc_slot  = (count_q == CNT_WIDTH'(PC_SLOT));
  // Truncation to the memory address width gives the silent modulo wrap.
  assign frame_address = base + MEM_ADDR_WIDTH'(count_q);

endmodule

// File: rtl/context_swap_unit.sv
// Saves or restores one 32-register context plus PC as a 33-word memory frame.
module context_swap_unit
  import context_swap_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk_write,
  input  logic                      reset,
  input  logic                      start_save,
  input  logic                      start_restore,
  input  logic [MEM_ADDR_WIDTH-1:0] base_address,
  input  logic [DATA_WIDTH-1:0]     save_pc,
  input  logic [DATA_WIDTH-1:0]     rb_data,
  input  logic [DATA_WIDTH-1:0]     mem_read_data,
  output logic [ADDR_WIDTH-1:0]     rb_read_address,
  output logic [ADDR_WIDTH-1:0]     rb_write_address,
  output logic [DATA_WIDTH-1:0]     rb_write_data,
  output logic                      rb_write_flag,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]     mem_write_data,
  output logic                      mem_write_enable,
  output logic [DATA_WIDTH-1:0]     restored_pc,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0]     save_pc_q, save_pc_d;
  logic [DATA_WIDTH-1:0]     restored_pc_q, restored_pc_d;

  logic                      cnt_clear;
  logic                      cnt_inc;
  logic [CNT_WIDTH-1:0]      count;
  logic                      last_reg;
  logic                      pc_slot;
  logic [MEM_ADDR_WIDTH-1:0] frame_address;

  context_frame_counter #(
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_counter (
    .clk           (clk_write),
    .reset         (reset),
    .clear         (cnt_clear),
    .inc           (cnt_inc),
    .base          (base_q),
    .count         (count),
    .last_reg      (last_reg),
    .pc_slot       (pc_slot),
    .frame_address (frame_address)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    save_pc_d        = save_pc_q;
    restored_pc_d    = restored_pc_q;
    cnt_clear        = 1'b0;
    cnt_inc          = 1'b0;
    rb_read_address  = '0;
    rb_write_address = '0;
    rb_write_data    = '0;
    rb_write_flag    = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Save wins a simultaneous request; the restore is simply dropped.
        if (start_save) begin
          base_d    = base_address;
          save_pc_d = save_pc;
          cnt_clear = 1'b1;
          state_d   = SAVE;
        end else if (start_restore) begin
          base_d    = base_address;
          cnt_clear = 1'b1;
          state_d   = RESTORE;
        end
      end

      SAVE: begin
        busy             = 1'b1;
        rb_read_address  = count[ADDR_WIDTH-1:0];
        mem_address      = frame_address;
        mem_write_data   = rb_data;
        mem_write_enable = 1'b1;
        cnt_inc          = 1'b1;
        if (last_reg) begin
          state_d = SAVE_PC;
        end
      end

      SAVE_PC: begin
        busy             = 1'b1;
        mem_address      = frame_address;
        mem_write_data   = save_pc_q;
        mem_write_enable = 1'b1;
        state_d          = DONE;
      end

      RESTORE: begin
        busy        = 1'b1;
        mem_address = frame_address;
        // Read data lags the address by one cycle, so write back the previous word.
        if (count != '0) begin
          rb_write_flag    = 1'b1;
          rb_write_address = count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
          rb_write_data    = mem_read_data;
        end
        if (pc_slot) begin
          state_d = RESTORE_DRAIN;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      RESTORE_DRAIN: begin
        busy          = 1'b1;
        restored_pc_d = mem_read_data;
        state_d       = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_write) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      save_pc_q     <= '0;
      restored_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      save_pc_q     <= save_pc_d;
      restored_pc_q <= restored_pc_d;
    end
  end

  assign restored_pc = restored_pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_context_swap_unit.sv
// Directed bench for context_swap_unit with bank/memory models and event counters.
module tb_context_swap_unit;

  logic        clk_write;
  logic        reset;
  logic        start_save;
  logic        start_restore;
  logic [9:0]  base_address;
  logic [31:0] save_pc;
  logic [31:0] rb_data;
  logic [31:0] mem_read_data;
  logic [4:0]  rb_read_address;
  logic [4:0]  rb_write_address;
  logic [31:0] rb_write_data;
  logic        rb_write_flag;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] restored_pc;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  logic [31:0] bank [32];
  logic [31:0] mem  [1024];

  int mem_wr_cnt, bank_wr_cnt, busy_cnt, done_cnt, both_cnt;
  int n_total, n_pass;
  logic [9:0] wr_addr_q [$];
  logic [9:0] exp_q [$];

  context_swap_unit dut (
    .clk_write        (clk_write),
    .reset            (reset),
    .start_save       (start_save),
    .start_restore    (start_restore),
    .base_address     (base_address),
    .save_pc          (save_pc),
    .rb_data          (rb_data),
    .mem_read_data    (mem_read_data),
    .rb_read_address  (rb_read_address),
    .rb_write_address (rb_write_address),
    .rb_write_data    (rb_write_data),
    .rb_write_flag    (rb_write_flag),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .restored_pc      (restored_pc),
    .busy             (busy),
    .done             (done),
    .dbg_state        (dbg_state)
  );

  // Clock
  initial clk_write = 1'b0;
  always #5 clk_write = ~clk_write;

  assign rb_data = bank[rb_read_address];

  // Bank and memory models plus event counters
  always @(posedge clk_write) begin
    mem_read_data <= mem[mem_address];
    if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data;
      mem_wr_cnt++;
      wr_addr_q.push_back(mem_address);
    end
    if (rb_write_flag) begin
      bank[rb_write_address] <= rb_write_data;
      bank_wr_cnt++;
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_write_enable && rb_write_flag) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_counters();
    mem_wr_cnt  = 0;
    bank_wr_cnt = 0;
    busy_cnt    = 0;
    done_cnt    = 0;
    wr_addr_q.delete();
  endtask

  task automatic pulse(input logic do_save, input logic do_restore,
                       input logic [9:0] base, input logic [31:0] pc);
    @(negedge clk_write);
    start_save    = do_save;
    start_restore = do_restore;
    base_address  = base;
    save_pc       = pc;
    @(negedge clk_write);
    start_save    = 1'b0;
    start_restore = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk_write);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk_write);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    both_cnt = 0;
    clear_counters();
    reset = 1'b1;
    start_save = 1'b0;
    start_restore = 1'b0;
    base_address = '0;
    save_pc = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'hDEAD_0000 | 32'(a);
    for (int n = 0; n < 32; n++) bank[n] = 32'(n * 3);

    // Reset state
    repeat (3) @(negedge clk_write);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_restored_pc", restored_pc, 32'd0);
    check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_rb_wf", {31'd0, rb_write_flag}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_address}, 32'd0);
    reset = 1'b0;

    // Save at base 100
    clear_counters();
    pulse(1'b1, 1'b0, 10'd100, 32'h400);
    wait_done("save_done_seen");
    check("save_busy_cycles", busy_cnt, 33);
    check("save_mem_writes", mem_wr_cnt, 33);
    check("save_done_count", done_cnt, 1);
    check("save_bank_writes", bank_wr_cnt, 0);
    for (int n = 0; n < 32; n++) check($sformatf("save_mem_%0d", 100 + n), mem[100 + n], 32'(n * 3));
    check("save_mem_pc", mem[132], 32'h400);

    // Restore from base 200
    for (int n = 0; n < 32; n++) mem[200 + n] = 32'hA000 + 32'(n);
    mem[232] = 32'h77;
    clear_counters();
    pulse(1'b0, 1'b1, 10'd200, 32'h0);
    wait_done("rest_done_seen");
    for (int n = 0; n < 32; n++) check($sformatf("rest_bank_%0d", n), bank[n], 32'hA000 + 32'(n));
    check("rest_pc", restored_pc, 32'h77);
    check("rest_busy_cycles", busy_cnt, 34);
    check("rest_mem_writes", mem_wr_cnt, 0);
    check("rest_bank_writes", bank_wr_cnt, 32);
    check("rest_done_count", done_cnt, 1);

    // Simultaneous starts, then a restore request while busy
    for (int n = 0; n < 32; n++) bank[n] = 32'h500 + 32'(n);
    clear_counters();
    pulse(1'b1, 1'b1, 10'd300, 32'h55);
    repeat (4) @(negedge clk_write);
    start_restore = 1'b1;
    @(negedge clk_write);
    start_restore = 1'b0;
    wait_done("both_done_seen");
    repeat (40) @(negedge clk_write);
    check("both_mem_writes", mem_wr_cnt, 33);
    check("both_bank_writes", bank_wr_cnt, 0);
    check("both_done_count", done_cnt, 1);
    check("both_busy_cycles", busy_cnt, 33);
    check("both_mem_r0", mem[300], 32'h500);
    check("both_mem_r31", mem[331], 32'h51F);
    check("both_mem_pc", mem[332], 32'h55);
    check("pc_held", restored_pc, 32'h77);

    // Address wrap from base 1020
    clear_counters();
    exp_q.delete();
    for (int k = 0; k < 33; k++) exp_q.push_back(10'((1020 + k) % 1024));
    pulse(1'b1, 1'b0, 10'd1020, 32'h99);
    wait_done("wrap_done_seen");
    check("wrap_write_count", wr_addr_q.size(), 33);
    for (int k = 0; k < 33 && k < wr_addr_q.size(); k++)
      check($sformatf("wrap_addr_%0d", k), {22'd0, wr_addr_q[k]}, {22'd0, exp_q[k]});
    check("wrap_mem_28", mem[28], 32'h99);
    check("wrap_mem_1023", mem[1023], 32'h503);

    // Reset during SAVE cycle 10
    clear_counters();
    pulse(1'b1, 1'b0, 10'd400, 32'h1234);
    repeat (10) @(negedge clk_write);
    reset = 1'b1;
    @(negedge clk_write);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mem_we", {31'd0, mem_write_enable}, 32'd0);
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    check("abort_mem_writes", mem_wr_cnt, 11);
    check("abort_done_count", done_cnt, 0);
    reset = 1'b0;
    clear_counters();
    pulse(1'b1, 1'b0, 10'd400, 32'h1234);
    wait_done("resave_done_seen");
    check("resave_busy_cycles", busy_cnt, 33);
    check("resave_mem_writes", mem_wr_cnt, 33);
    check("resave_mem_pc", mem[432], 32'h1234);

    // Round trip through base 50
    for (int n = 0; n < 32; n++) bank[n] = 32'h1000_0000 + 32'(n * 7);
    pulse(1'b1, 1'b0, 10'd50, 32'hCAFE);
    wait_done("rt_save_done");
    for (int n = 0; n < 32; n++) bank[n] = 32'hFFFF_FFFF;
    pulse(1'b0, 1'b1, 10'd50, 32'h0);
    wait_done("rt_rest_done");
    for (int n = 0; n < 32; n++) check($sformatf("rt_bank_%0d", n), bank[n], 32'h1000_0000 + 32'(n * 7));
    check("rt_pc", restored_pc, 32'hCAFE);

    check("never_both_strobes", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/context_swap_unit.md
Name: context_swap_unit

Overview:
- Moves one 32-entry register context between the register bank and data memory for process context switches.
- Save: reads bank registers 0..31 and the stored process PC, and streams them to memory at a base address.
- Restore: reads the same 33-word frame from memory, writes registers 0..31 back into the bank, and returns the restored PC.
- Sits beside the register bank on the divided clock domain; the control unit starts it and then stalls on busy.

Parameters:
DATA_WIDTH, 32, register/memory word width
ADDR_WIDTH, 5, register index width (32 registers)
MEM_ADDR_WIDTH, 10, data memory word-address width
FRAME_WORDS, 33, words per context frame (32 registers + PC)

Ports:
clk_write  in  1  divided core clock; all state on rising edge
reset  in  1  synchronous, active-high reset
start_save  in  1  one-cycle pulse: begin save
start_restore  in  1  one-cycle pulse: begin restore
base_address  in  MEM_ADDR_WIDTH  frame base, sampled on accepted start
save_pc  in  DATA_WIDTH  process PC to store in the frame, sampled on accepted save start
rb_data  in  DATA_WIDTH  combinational bank read data for rb_read_address
mem_read_data  in  DATA_WIDTH  memory read data; valid one cycle after address
rb_read_address  out  ADDR_WIDTH  bank read index
rb_write_address  out  ADDR_WIDTH  bank write index
rb_write_data  out  DATA_WIDTH  bank write data
rb_write_flag  out  1  bank write strobe
mem_address  out  MEM_ADDR_WIDTH  memory word address
mem_write_data  out  DATA_WIDTH  memory write data
mem_write_enable  out  1  memory write strobe
restored_pc  out  DATA_WIDTH  PC loaded from frame word 32; held until the next restore
busy  out  1  operation in progress
done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0 (including restored_pc, busy, done).
- Reset asserted mid-operation aborts immediately. Partial memory or bank writes are not undone.
- States are IDLE, SAVE, SAVE_PC, RESTORE, RESTORE_DRAIN and DONE.
- IDLE:
  - start_save has priority over start_restore when both are high in the same cycle; the restore request is dropped.
  - On an accepted start, latch base_address (and save_pc for a save), clear counter i, and set busy next cycle.
- SAVE (i = 0..31), one register per cycle:
  - rb_read_address = i; mem_address = base + i; mem_write_data = rb_data; mem_write_enable = 1.
  - After i = 31, go to SAVE_PC.
- SAVE_PC: mem_address = base + 32; mem_write_data = latched save_pc; mem_write_enable = 1. Next state DONE.
- Save duration: busy high for exactly 33 cycles with 33 memory writes, then done for one cycle.
- RESTORE (i = 0..32), pipelined with one-cycle memory latency:
  - Cycle k issues mem_address = base + k.
  - In cycle k+1, for k ≤ 31: rb_write_address = k; rb_write_data = mem_read_data; rb_write_flag = 1.
  - The word for k = 32 is captured into restored_pc in cycle 33 (RESTORE_DRAIN).
- Restore duration: busy high for 34 cycles with 32 bank writes and no memory writes, then DONE.
- DONE: done = 1 and busy = 0 for one cycle; return to IDLE. A start in this cycle is ignored.
- Start pulses while busy are ignored and not queued.
- Address arithmetic is modulo 2^MEM_ADDR_WIDTH, so base + i wraps silently (base 1020 with width 10 wraps to 0..28).
- rb_write_flag and mem_write_enable are never high in the same cycle. Both are 0 outside SAVE, SAVE_PC and RESTORE write cycles.
- Register 28 (interrupt/PROC_PC slot) and register 31 (link) are saved and restored like any other register.
- Bank selection (shift enabler) is driven by the control unit, not this block.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 0, SAVE = 1, SAVE_PC = 2, RESTORE = 3, RESTORE_DRAIN = 4, DONE = 5;
  - FRAME_WORDS;
  - PC_SLOT = 32.
- One sub-module is natural: context_frame_counter, holding the i counter, terminal-count flags (i == 31, i == 32) and the base + i adder with wrap.

Test Plan:
- Save: preload bank reg n = n×3, base_address 100, save_pc 0x400 → 33 writes mem[100+n] = n×3 and mem[132] = 0x400; busy 33 cycles; done once.
- Restore: frame at 200 with mem[200+n] = 0xA000+n, mem[232] = 0x77 → bank reg n = 0xA000+n, restored_pc = 0x77, busy 34 cycles, no mem writes.
- Simultaneous start_save and start_restore → only the save runs. A start_restore during busy is ignored: no second done, and no bank writes.
- Wrap: base_address 1020, save → writes to addresses 1020..1023, then 0..28.
- Reset asserted in SAVE cycle 10 → next cycle busy = 0, mem_write_enable = 0, state IDLE; a new save then runs a full 33-cycle frame.
- Round trip: save at 50, corrupt the bank, restore from 50 → bank contents and restored_pc match the pre-save values.
